// File: rtl/diagv2_ecall_ctrl.sv
// Environment-call controller for the diagv2 core. It freezes the core on an ecall and
// services PRINT (streams a null-terminated string from dmem) and EXIT (records the
// exit code and halts forever). Any other syscall number halts with an error flag.
module diagv2_ecall_ctrl #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned MAX_LEN = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ecall,
  input  logic [DATA_W-1:0] a7,
  input  logic [DATA_W-1:0] a0,
  output logic              halt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              exit_valid,
  output logic [DATA_W-1:0] exit_code,
  output logic              err_invalid,
  output logic              print_trunc
);

  localparam int unsigned CntW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StEmit, StRelease, StExited, StError
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   line_q, line_d;
  logic [2:0]          offset_q, offset_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                exit_valid_q, exit_valid_d;
  logic [DATA_W-1:0]   exit_code_q, exit_code_d;
  logic                err_q, err_d;
  logic                trunc_q, trunc_d;
  logic [7:0]          cur_byte;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      line_q       <= '0;
      offset_q     <= '0;
      count_q      <= '0;
      buf_q        <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
      err_q        <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      offset_q     <= offset_d;
      count_q      <= count_d;
      buf_q        <= buf_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
      err_q        <= err_d;
      trunc_q      <= trunc_d;
    end
  end

  // Next-state decode and combinational outputs.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    offset_d     = offset_q;
    count_d      = count_q;
    buf_d        = buf_q;
    exit_valid_d = exit_valid_q;
    exit_code_d  = exit_code_q;
    err_d        = err_q;
    trunc_d      = trunc_q;
    halt         = 1'b1;
    rd_en        = 1'b0;
    char_valid   = 1'b0;
    char_data    = 8'h00;
    cur_byte     = buf_q[{offset_q, 3'b000} +: 8];

    case (state_q)
      StIdle: begin
        // Stall in the same cycle the ecall shows up.
        halt = ecall;
        if (ecall) begin
          if (a7 == DATA_W'(4)) begin
            line_d   = a0[ADDR_W+2:3];
            offset_d = a0[2:0];
            count_d  = '0;
            trunc_d  = 1'b0;
            state_d  = StFetch;
          end else if (a7 == DATA_W'(93)) begin
            exit_code_d  = a0;
            exit_valid_d = 1'b1;
            state_d      = StExited;
          end else begin
            err_d   = 1'b1;
            state_d = StError;
          end
        end
      end
      StFetch: begin
        rd_en   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        buf_d   = rd_data;
        state_d = StEmit;
      end
      StEmit: begin
        if (cur_byte == 8'h00) begin
          state_d = StRelease;
        end else if (count_q == CntW'(MAX_LEN)) begin
          trunc_d = 1'b1;
          state_d = StRelease;
        end else begin
          char_valid = 1'b1;
          char_data  = cur_byte;
          if (char_ready) begin
            count_d = count_q + CntW'(1);
            if (offset_q == 3'd7) begin
              offset_d = 3'd0;
              line_d   = line_q + ADDR_W'(1);
              state_d  = StFetch;
            end else begin
              offset_d = offset_q + 3'd1;
            end
          end
        end
      end
      StRelease: begin
        // One free cycle lets the core retire the ecall so it is not re-taken.
        halt    = 1'b0;
        trunc_d = 1'b0;
        state_d = StIdle;
      end
      StExited, StError: ;
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr     = line_q;
  assign exit_valid  = exit_valid_q;
  assign exit_code   = exit_code_q;
  assign err_invalid = err_q;
  assign print_trunc = (state_q == StRelease) && trunc_q;

endmodule

// File: tb/tb_diagv2_ecall_ctrl.sv
// Directed bench for diagv2_ecall_ctrl: a default instance and a MAX_LEN=3 instance.
module tb_diagv2_ecall_ctrl;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          ecall, ecall2;
  logic [63:0]   a7, a0;
  logic          char_ready;

  logic          halt, rd_en, char_valid, exit_valid, err_invalid, print_trunc;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data, exit_code;
  logic [7:0]    char_data;

  logic          halt2, rd_en2, char_valid2, exit_valid2, err_invalid2, print_trunc2;
  logic [AW-1:0] rd_addr2;
  logic [63:0]   rd_data2, exit_code2;
  logic [7:0]    char_data2;

  logic [63:0]   mem [0:4095];

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [7:0]    chars [$];
  int            times [$];
  logic [AW-1:0] reads [$];

  always #5 clk = ~clk;

  diagv2_ecall_ctrl u_dut (
    .clk(clk), .reset(reset), .ecall(ecall), .a7(a7), .a0(a0), .halt(halt),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .exit_valid(exit_valid),
    .exit_code(exit_code), .err_invalid(err_invalid), .print_trunc(print_trunc)
  );

  diagv2_ecall_ctrl #(.MAX_LEN(3)) u_trunc (
    .clk(clk), .reset(reset), .ecall(ecall2), .a7(a7), .a0(a0), .halt(halt2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .char_valid(char_valid2),
    .char_data(char_data2), .char_ready(char_ready), .exit_valid(exit_valid2),
    .exit_code(exit_code2), .err_invalid(err_invalid2), .print_trunc(print_trunc2)
  );

  // Data memory with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= mem[rd_addr];
    if (rd_en2) rd_data2 <= mem[rd_addr2];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a PRINT on the default instance and run until halt drops (in RELEASE).
  task automatic run_print(input logic [63:0] addr, input bit toggle, output int edges);
    logic       v, r;
    logic [7:0] d;
    chars.delete();
    times.delete();
    reads.delete();
    a7    = 64'd4;
    a0    = addr;
    ecall = 1'b1;
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      v = char_valid;
      r = char_ready;
      d = char_data;
      if (v && r) begin
        chars.push_back(d);
        times.push_back(edges);
      end
      if (rd_en) reads.push_back(rd_addr);
      tick();
      edges++;
      if (v && !r) begin
        chk("hold_valid", {63'd0, char_valid}, 64'd1);
        chk("hold_data", {56'd0, char_data}, {56'd0, d});
      end
      if (toggle) char_ready = ~char_ready;
      if (!halt) break;
    end
    ecall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            edges;
    int            lows;
    logic [47:0]   hello;
    logic [31:0]   abcd;
    logic [23:0]   digits;

    hello  = 48'h21_6F_6C_6C_65_48;
    abcd   = 32'h44_43_42_41;
    digits = 24'h32_31_30;
    mem[12'h10] = 64'h0000_21_6F_6C_6C_65_48;
    mem[12'h20] = 64'h37_36_35_34_33_32_31_30;
    mem[12'h21] = 64'h0000_0000_0000_3938;

    // Reset held with an EXIT ecall pending: halt follows ecall, nothing is taken.
    reset = 1'b0; ecall = 1'b1; ecall2 = 1'b0; a7 = 64'd93; a0 = 64'd7; char_ready = 1'b1;
    tick();
    tick();
    chk("rst_halt_follows", {63'd0, halt}, 64'd1);
    chk("rst_exit_valid", {63'd0, exit_valid}, 64'd0);
    ecall = 1'b0;
    #1;
    chk("rst_halt_low", {63'd0, halt}, 64'd0);
    reset = 1'b1;
    tick();
    chk("rst_regs", {exit_code, 3'd0, err_invalid, print_trunc, char_valid, rd_en,
                     exit_valid}, 72'd0);
    chk("rst_addr_data", {44'd0, rd_addr, char_data}, 64'd0);

    // Aligned PRINT "Hello!".
    run_print(64'h80, 1'b0, edges);
    chk("hello_release_edges", edges, 10);
    chk("hello_trunc", {63'd0, print_trunc}, 64'd0);
    chk("hello_len", chars.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk("hello_char", {56'd0, chars[i]}, {56'd0, hello[i*8 +: 8]});
      chk("hello_time", times[i], 3 + i);
    end
    chk("hello_reads", reads.size(), 1);
    chk("hello_addr", {52'd0, reads[0]}, 64'h10);
    tick();
    chk("hello_idle_halt", {63'd0, halt}, 64'd0);

    // Unaligned PRINT crossing a word boundary.
    mem[12'h10] = 64'h43_42_41_00_00_00_00_00;
    mem[12'h11] = 64'h0000_0000_0000_0044;
    run_print(64'h85, 1'b0, edges);
    chk("abcd_release_edges", edges, 10);
    chk("abcd_len", chars.size(), 4);
    for (int i = 0; i < 4; i++) chk("abcd_char", {56'd0, chars[i]}, {56'd0, abcd[i*8 +: 8]});
    chk("abcd_gap", times[3] - times[2], 3);
    chk("abcd_reads", reads.size(), 2);
    chk("abcd_addr0", {52'd0, reads[0]}, 64'h10);
    chk("abcd_addr1", {52'd0, reads[1]}, 64'h11);
    tick();

    // Backpressure: char_ready toggles every cycle.
    mem[12'h10] = 64'h0000_21_6F_6C_6C_65_48;
    run_print(64'h80, 1'b1, edges);
    char_ready = 1'b1;
    chk("bp_release_edges", edges, 16);
    chk("bp_len", chars.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_char", {56'd0, chars[i]}, {56'd0, hello[i*8 +: 8]});
    tick();

    // MAX_LEN=3 instance with a 10-character string.
    chars.delete();
    a7 = 64'd4; a0 = 64'h100; ecall2 = 1'b1;
    edges = 0;
    for (int i = 0; i < 200; i++) begin
      if (char_valid2 && char_ready) chars.push_back(char_data2);
      tick();
      edges++;
      if (!halt2) break;
    end
    chk("trunc_release_edges", edges, 7);
    chk("trunc_pulse", {63'd0, print_trunc2}, 64'd1);
    ecall2 = 1'b0;
    tick();
    chk("trunc_pulse_end", {63'd0, print_trunc2}, 64'd0);
    chk("trunc_len", chars.size(), 3);
    for (int i = 0; i < 3; i++) chk("trunc_char", {56'd0, chars[i]}, {56'd0, digits[i*8 +: 8]});

    // Reset in the middle of a PRINT abandons the pending character.
    run_print(64'h80, 1'b0, edges);
    tick();
    a7 = 64'd4; a0 = 64'h80; ecall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_valid", {63'd0, char_valid}, 64'd1);
    reset = 1'b0; ecall = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst", {61'd0, char_valid, halt, rd_en}, 64'd0);

    // EXIT.
    a7 = 64'd93; a0 = 64'd7; ecall = 1'b1;
    #1;
    chk("exit_halt_comb", {63'd0, halt}, 64'd1);
    tick();
    ecall = 1'b0;
    chk("exit_valid", {63'd0, exit_valid}, 64'd1);
    chk("exit_code", exit_code, 64'd7);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (halt !== 1'b1) lows++;
    end
    chk("exit_halt_hold", lows, 0);
    chk("exit_no_err", {63'd0, err_invalid}, 64'd0);

    // Invalid syscall after a reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("exit_cleared", {63'd0, exit_valid}, 64'd0);
    a7 = 64'd5; ecall = 1'b1;
    tick();
    ecall = 1'b0;
    chk("err_flag", {63'd0, err_invalid}, 64'd1);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halt !== 1'b1 || err_invalid !== 1'b1) lows++;
    end
    chk("err_hold", lows, 0);
    chk("err_no_exit", {63'd0, exit_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
